// File: rtl/snake_grid_renderer.sv
// Snake grid renderer: rasterises the segment list into a double-buffered occupancy bitmap
// once per frame and colours pixels by bitmap lookup. Optional macro GRID_LINES_EN draws cell borders.
module snake_grid_renderer #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int CELL_PX  = 30,
  parameter int MAX_LEN  = 16,
  parameter int LOC_W    = 8,
  parameter int H_ORIGIN = 144,
  parameter int V_ORIGIN = 35
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Bright,
  input  logic [9:0]                   hCount,
  input  logic [9:0]                   vCount,
  input  logic                         Qi,
  input  logic                         Qw,
  input  logic                         Ql,
  input  logic                         Qc,
  input  logic [LOC_W-1:0]             Food,
  input  logic [$clog2(MAX_LEN+1)-1:0] Length,
  input  logic [MAX_LEN*LOC_W-1:0]     Locations_Flat,
  output logic [11:0]                  rgb,
  output logic [11:0]                  background,
  output logic                         busy
);

  // state  | meaning
  // IDLE   | after reset, waiting for the first frame boundary
  // CLEAR  | zero the back bitmap and invalidate the back head
  // SCAN   | one segment per cycle into the back bitmap / head register
  // READY  | back buffer complete, waiting to swap at the next frame boundary
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN, S_READY} state_t;

  localparam int CELLS = GRID_W * GRID_H;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int HC_W  = $clog2(GRID_W + 1);
  localparam int VC_W  = $clog2(GRID_H + 1);

  localparam logic [9:0]       H_LO    = 10'(H_ORIGIN);
  localparam logic [9:0]       H_HI    = 10'(H_ORIGIN + GRID_W * CELL_PX);
  localparam logic [9:0]       H_RLD   = 10'(H_ORIGIN - 1);
  localparam logic [9:0]       V_LO    = 10'(V_ORIGIN);
  localparam logic [9:0]       V_HI    = 10'(V_ORIGIN + GRID_H * CELL_PX);
  localparam logic [9:0]       V_RLD   = 10'(V_ORIGIN - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CELL_PX - 1);
  localparam logic [LOC_W:0]   CELLS_L = (LOC_W + 1)'(CELLS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  localparam logic [11:0] C_HEAD = 12'hF80;
  localparam logic [11:0] C_BODY = 12'hFF0;
  localparam logic [11:0] C_FOOD = 12'hFFF;
`ifdef GRID_LINES_EN
  localparam logic [11:0] C_GRID = 12'h444;
`endif

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           idx_q, idx_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [MAX_LEN*LOC_W-1:0]   locs_q, locs_d;
  logic [LOC_W-1:0]           food_snap_q, food_snap_d;
  logic                       food_snap_vld_q, food_snap_vld_d;
  logic [CELLS-1:0]           back_q, back_d;
  logic [CELLS-1:0]           front_q, front_d;
  logic [LOC_W-1:0]           head_q, head_d;
  logic                       head_vld_q, head_vld_d;
  logic [LOC_W-1:0]           head_disp_q, head_disp_d;
  logic                       head_disp_vld_q, head_disp_vld_d;
  logic [LOC_W-1:0]           food_disp_q, food_disp_d;
  logic                       food_disp_vld_q, food_disp_vld_d;

  logic [SUB_W-1:0]           hsub_q, hsub_d, vsub_q, vsub_d;
  logic [HC_W-1:0]            hcell_q, hcell_d;
  logic [VC_W-1:0]            vcell_q, vcell_d;
  logic [11:0]                rgb_q, rgb_d;
  logic [11:0]                bg_q, bg_d;

  logic                       frame_start;
  logic                       take_snap;
  logic [LOC_W-1:0]           seg;
  logic                       seg_ok;
  logic                       in_grid;
  int                         pix_cell_int;
  logic [LOC_W-1:0]           pix_cell;

  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
  assign seg         = locs_q[MAX_LEN*LOC_W-1 -: LOC_W];
  assign seg_ok      = ({1'b0, seg} < CELLS_L);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    len_d           = len_q;
    locs_d          = locs_q;
    food_snap_d     = food_snap_q;
    food_snap_vld_d = food_snap_vld_q;
    back_d          = back_q;
    front_d         = front_q;
    head_d          = head_q;
    head_vld_d      = head_vld_q;
    head_disp_d     = head_disp_q;
    head_disp_vld_d = head_disp_vld_q;
    food_disp_d     = food_disp_q;
    food_disp_vld_d = food_disp_vld_q;
    take_snap       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) take_snap = 1'b1;
      end
      S_CLEAR: begin
        back_d     = '0;
        head_vld_d = 1'b0;
        idx_d      = '0;
        state_d    = (len_q == '0) ? S_READY : S_SCAN;
      end
      S_SCAN: begin
        if (idx_q == '0) begin
          head_d     = seg;
          head_vld_d = seg_ok;
        end else if (seg_ok) begin
          back_d[seg] = 1'b1;
        end
        locs_d = locs_q << LOC_W;
        idx_d  = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1)) state_d = S_READY;
      end
      S_READY: begin
        if (frame_start) begin
          front_d         = back_q;
          head_disp_d     = head_q;
          head_disp_vld_d = head_vld_q;
          if (food_snap_vld_q) begin
            food_disp_d     = food_snap_q;
            food_disp_vld_d = 1'b1;
          end
          take_snap = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot shared by the first boundary and every later swap boundary.
    if (take_snap) begin
      locs_d          = Locations_Flat;
      len_d           = (Length > LEN_MAX) ? LEN_MAX : Length;
      food_snap_d     = Food;
      food_snap_vld_d = Qc;
      state_d         = S_CLEAR;
    end
  end

  always_comb begin
    hsub_d  = hsub_q;
    hcell_d = hcell_q;
    vsub_d  = vsub_q;
    vcell_d = vcell_q;
    if (hCount == H_RLD) begin
      hsub_d  = '0;
      hcell_d = '0;
    end else if (hsub_q == SUB_MAX) begin
      hsub_d  = '0;
      hcell_d = hcell_q + HC_W'(1);
    end else begin
      hsub_d = hsub_q + SUB_W'(1);
    end
    // Preload one step before cell 0 so the first advance on the top row lands on 0/0.
    if (vCount == V_RLD) begin
      vsub_d  = SUB_MAX;
      vcell_d = '1;
    end else if (hCount == 10'd0) begin
      if (vsub_q == SUB_MAX) begin
        vsub_d  = '0;
        vcell_d = vcell_q + VC_W'(1);
      end else begin
        vsub_d = vsub_q + SUB_W'(1);
      end
    end
  end

  assign in_grid      = (hCount >= H_LO) && (hCount < H_HI) && (vCount >= V_LO) && (vCount < V_HI);
  assign pix_cell_int = int'(vcell_q) * GRID_W + int'(hcell_q);
  assign pix_cell     = LOC_W'(pix_cell_int);

  always_comb begin
    rgb_d = '0;
    if (Bright) begin
      rgb_d = bg_q;
      if (in_grid) begin
        if (head_disp_vld_q && (pix_cell == head_disp_q)) rgb_d = C_HEAD;
        else if (front_q[pix_cell])                       rgb_d = C_BODY;
        else if (food_disp_vld_q && (pix_cell == food_disp_q)) rgb_d = C_FOOD;
`ifdef GRID_LINES_EN
        else if ((hsub_q == '0) || (vsub_q == '0))        rgb_d = C_GRID;
`endif
      end
    end
  end

  always_comb begin
    bg_d = 12'h000;
    if (Qi)      bg_d = 12'h000;
    else if (Ql) bg_d = 12'hF00;
    else if (Qw) bg_d = 12'h0F0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      len_q           <= '0;
      locs_q          <= '0;
      food_snap_q     <= '0;
      food_snap_vld_q <= 1'b0;
      back_q          <= '0;
      front_q         <= '0;
      head_q          <= '0;
      head_vld_q      <= 1'b0;
      head_disp_q     <= '0;
      head_disp_vld_q <= 1'b0;
      food_disp_q     <= '0;
      food_disp_vld_q <= 1'b0;
      hsub_q          <= '0;
      hcell_q         <= '0;
      vsub_q          <= '0;
      vcell_q         <= '0;
      rgb_q           <= '0;
      bg_q            <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      len_q           <= len_d;
      locs_q          <= locs_d;
      food_snap_q     <= food_snap_d;
      food_snap_vld_q <= food_snap_vld_d;
      back_q          <= back_d;
      front_q         <= front_d;
      head_q          <= head_d;
      head_vld_q      <= head_vld_d;
      head_disp_q     <= head_disp_d;
      head_disp_vld_q <= head_disp_vld_d;
      food_disp_q     <= food_disp_d;
      food_disp_vld_q <= food_disp_vld_d;
      hsub_q          <= hsub_d;
      hcell_q         <= hcell_d;
      vsub_q          <= vsub_d;
      vcell_q         <= vcell_d;
      rgb_q           <= rgb_d;
      bg_q            <= bg_d;
    end
  end

  assign rgb        = rgb_q;
  assign background = bg_q;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_SCAN);

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Directed bench for snake_grid_renderer: compressed raster frames, pixel vector table,
// background vector table and hand-written reset / busy / food-latency sequences.
module tb_snake_grid_renderer;

  localparam int H0 = 144;
  localparam int GW = 16;
  localparam int CP = 30;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Bright;
  logic [9:0]   hCount, vCount;
  logic         Qi, Qw, Ql, Qc;
  logic [7:0]   Food;
  logic [4:0]   Length;
  logic [127:0] Locations_Flat;
  logic [11:0]  rgb, background;
  logic         busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   dark    = 1'b0;
  logic [11:0] cap [0:524][0:639];
  logic        busy_log [0:19];

  typedef struct {int phase; int h; int v; logic [11:0] exp;} pix_vec_t;
  typedef struct {logic qi; logic qw; logic ql; logic [11:0] exp;} bg_vec_t;
  pix_vec_t pv[$];
  bg_vec_t  bv[$];

  snake_grid_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Bright(Bright), .hCount(hCount), .vCount(vCount),
    .Qi(Qi), .Qw(Qw), .Ql(Ql), .Qc(Qc), .Food(Food), .Length(Length),
    .Locations_Flat(Locations_Flat), .rgb(rgb), .background(background), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_sample(input int v);
    return v == 35 || v == 64 || v == 65 || v == 94 || v == 95 ||
           v == 185 || v == 214 || v == 275;
  endfunction

  task automatic add_pix(input int p, input int h, input int v, input logic [11:0] e);
    pix_vec_t t;
    t.phase = p; t.h = h; t.v = v; t.exp = e;
    pv.push_back(t);
  endtask

  task automatic add_bg(input logic qi, input logic qw, input logic ql, input logic [11:0] e);
    bg_vec_t t;
    t.qi = qi; t.qw = qw; t.ql = ql; t.exp = e;
    bv.push_back(t);
  endtask

  // One frame: one cycle per line at hCount=0, full grid sweep on sampled lines.
  task automatic run_frame(input bit capture);
    for (int v = 0; v < 525; v++) begin
      hCount = 10'd0; vCount = 10'(v); Bright = 1'b0;
      tick();
      if (v < 20) busy_log[v] = busy;
      if (capture && is_sample(v)) begin
        for (int h = H0 - 1; h <= H0 + GW * CP; h++) begin
          hCount = 10'(h); Bright = ~dark;
          tick();
          cap[v][h] = rgb;
        end
      end
    end
  endtask

  task automatic check_phase(input int p);
    foreach (pv[i]) begin
      if (pv[i].phase == p)
        check12($sformatf("pix p%0d h%0d v%0d", p, pv[i].h, pv[i].v),
                cap[pv[i].v][pv[i].h], pv[i].exp);
    end
  endtask

  function automatic int busy_count();
    int c = 0;
    for (int k = 0; k < 20; k++) if (busy_log[k]) c++;
    return c;
  endfunction

  initial begin
    // phase 1: one frame after the first snapshot, nothing displayed yet
    add_pix(1, 144, 35, 12'h000);
    add_pix(1, 173, 64, 12'h000);
    // phase 2: head at cell 0x00
    add_pix(2, 144, 35, 12'hF80);
    add_pix(2, 173, 35, 12'hF80);
    add_pix(2, 144, 64, 12'hF80);
    add_pix(2, 173, 64, 12'hF80);
    add_pix(2, 174, 35, 12'h000);
    add_pix(2, 144, 65, 12'h000);
    add_pix(2, 143, 35, 12'h000);
    add_pix(2, 174, 65, 12'h000);
    // phase 3: head 0x11, body 0x12/0x13, food 0x55
    add_pix(3, 174, 65, 12'hF80);
    add_pix(3, 203, 94, 12'hF80);
    add_pix(3, 204, 65, 12'hFF0);
    add_pix(3, 234, 65, 12'hFF0);
    add_pix(3, 263, 94, 12'hFF0);
    add_pix(3, 264, 65, 12'h000);
    add_pix(3, 294, 185, 12'hFFF);
    add_pix(3, 323, 214, 12'hFFF);
    add_pix(3, 324, 185, 12'h000);
    add_pix(3, 144, 35, 12'h000);
    // phase 4: 16 segments along row 8, clamp leaves cell 0 empty
    add_pix(4, 144, 275, 12'hF80);
    add_pix(4, 174, 275, 12'hFF0);
    add_pix(4, 594, 275, 12'hFF0);
    add_pix(4, 623, 275, 12'hFF0);
    add_pix(4, 624, 275, 12'h000);
    add_pix(4, 144, 35, 12'h000);
    add_pix(4, 174, 65, 12'h000);
    add_pix(4, 294, 185, 12'hFFF);
    // phases 5/6: food request with Qc=0 ignored, Qc=1 not yet visible
    add_pix(5, 294, 185, 12'hFFF);
    add_pix(5, 204, 95, 12'h000);
    add_pix(6, 294, 185, 12'hFFF);
    add_pix(6, 204, 95, 12'h000);
    // phase 7: food moved to 0x22
    add_pix(7, 204, 95, 12'hFFF);
    add_pix(7, 233, 95, 12'hFFF);
    add_pix(7, 294, 185, 12'h000);
    // phase 8: lose+win background
    add_pix(8, 144, 35, 12'hF00);
    add_pix(8, 143, 35, 12'hF00);
    add_pix(8, 624, 275, 12'hF00);
    add_pix(8, 144, 275, 12'hF80);
    add_pix(8, 294, 185, 12'hF00);
    add_pix(8, 204, 95, 12'hFFF);
    // phase 9: blanked
    add_pix(9, 144, 275, 12'h000);
    add_pix(9, 144, 35, 12'h000);

    add_bg(1'b0, 1'b0, 1'b0, 12'h000);
    add_bg(1'b0, 1'b1, 1'b0, 12'h0F0);
    add_bg(1'b0, 1'b0, 1'b1, 12'hF00);
    add_bg(1'b0, 1'b1, 1'b1, 12'hF00);
    add_bg(1'b1, 1'b1, 1'b1, 12'h000);
    add_bg(1'b1, 1'b0, 1'b0, 12'h000);

    Reset_n = 1'b0; Bright = 1'b0; hCount = 10'd0; vCount = 10'd1;
    Qi = 1'b0; Qw = 1'b0; Ql = 1'b0; Qc = 1'b0; Food = 8'h00;
    Length = 5'd3; Locations_Flat = {8'h11, 8'h12, 8'h13, 104'h0};
    repeat (3) tick();
    check12("reset rgb", rgb, 12'h000);
    check12("reset background", background, 12'h000);
    check_int("reset busy", int'(busy), 0);

    // Start a scan, then pull reset in the middle of it.
    Reset_n = 1'b1;
    hCount = 10'd0; vCount = 10'd0; tick();
    vCount = 10'd1; tick();
    vCount = 10'd2; tick();
    check_int("busy mid scan", int'(busy), 1);
    Reset_n = 1'b0; Bright = 1'b1; Ql = 1'b1; vCount = 10'd3;
    repeat (2) tick();
    check12("midscan reset rgb", rgb, 12'h000);
    check12("midscan reset background", background, 12'h000);
    check_int("midscan reset busy", int'(busy), 0);
    Reset_n = 1'b1; Bright = 1'b0; Ql = 1'b0;

    Length = 5'd1; Locations_Flat = '0;
    run_frame(1'b1);
    check_int("busy cycles len1", busy_count(), 2);
    check_phase(1);
    run_frame(1'b1);
    check_phase(2);

    Length = 5'd3; Locations_Flat = {8'h11, 8'h12, 8'h13, 104'h0};
    Qc = 1'b1; Food = 8'h55;
    run_frame(1'b0);
    check_int("busy cycles len3", busy_count(), 4);
    run_frame(1'b1);
    check_phase(3);

    Length = 5'd20;
    for (int i = 0; i < 16; i++) Locations_Flat[(15 - i) * 8 +: 8] = 8'h80 + 8'(i);
    run_frame(1'b0);
    check_int("busy cycles len20", busy_count(), 17);
    check_int("busy first cycle", int'(busy_log[0]), 1);
    run_frame(1'b1);
    check_phase(4);

    Food = 8'h22; Qc = 1'b0;
    run_frame(1'b0);
    run_frame(1'b1);
    check_phase(5);
    Qc = 1'b1;
    run_frame(1'b1);
    check_phase(6);
    run_frame(1'b1);
    check_phase(7);

    Ql = 1'b1; Qw = 1'b1;
    run_frame(1'b1);
    check_phase(8);
    check12("background lose+win", background, 12'hF00);
    dark = 1'b1;
    run_frame(1'b1);
    check_phase(9);
    dark = 1'b0;

    hCount = 10'd5; vCount = 10'd5; Bright = 1'b0;
    foreach (bv[i]) begin
      Qi = bv[i].qi; Qw = bv[i].qw; Ql = bv[i].ql;
      tick();
      check12($sformatf("background vec%0d", i), background, bv[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
